pll_drp_responder: RTL and testbench

- Synthesizable DRP target that models the PLL side of the reconfiguration port.
- Answers the 5-bit-address / 16-bit-data DRP handshake issued by the PLL reconfiguration sequencer, and holds a 32x16 register file.
- Models pll_locked behaviour around pll_rst.
- Includes sticky protocol checkers.
- Used in simulation benches and as a stand-in target in FPGA bring-up builds where the sequencer runs without a real PLL.

---
 rtl/pll_drp_pkg.sv | 24 ++
 rtl/pll_drp_lock_model.sv | 30 +++
 rtl/pll_drp_responder.sv | 110 +++++++++++
 tb/tb_pll_drp_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Shared DRP definitions for the PLL reconfiguration sequencer and its target.
`timescale 1ns/1ps
package pll_drp_pkg;
   localparam int DRP_AW   = 5;
   localparam int DRP_DW   = 16;
   localparam int DRP_NREG = 32;

   localparam int ERR_BUSY   = 0;
   localparam int ERR_UNSAFE = 1;
   localparam int ERR_W      = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } drp_state_t;

   function automatic logic [DRP_DW-1:0] drp_init_val(
      input logic [DRP_DW-1:0] base,
      input int                k
   );
      return base ^ DRP_DW'(k);
   endfunction
endpackage

// File: rtl/pll_drp_lock_model.sv
// Lock indication model: counts clean cycles after pll_rst_i falls.
`timescale 1ns/1ps
module pll_drp_lock_model #(
   parameter int g_lock_delay = 100
) (
   input  logic clk_a_i,
   input  logic rst_powerup,
   input  logic pll_rst_i,
   output logic pll_locked_o
);
   logic [15:0] r_cnt;
   logic        r_locked;

   always_ff @(posedge clk_a_i or posedge rst_powerup) begin
      if (rst_powerup) begin
         r_cnt    <= '0;
         r_locked <= 1'b0;
      end else if (pll_rst_i) begin
         r_cnt    <= '0;
         r_locked <= 1'b0;
      end else if (!r_locked) begin
         if (r_cnt == 16'(g_lock_delay - 1))
            r_locked <= 1'b1;
         else
            r_cnt <= r_cnt + 16'd1;
      end
   end

   assign pll_locked_o = r_locked;
endmodule

// File: rtl/pll_drp_responder.sv
// DRP target standing in for the PLL: register file, latency FSM, lock model,
// sticky protocol error flags.
`timescale 1ns/1ps
module pll_drp_responder
   import pll_drp_pkg::*;
#(
   parameter int          g_read_latency  = 3,
   parameter int          g_write_latency = 2,
   parameter int          g_lock_delay    = 100,
   parameter logic [15:0] g_init_base     = 16'hA500
) (
   input  logic              clk_a_i,
   input  logic              rst_powerup,
   input  logic [DRP_AW-1:0] drp_daddr_i,
   input  logic              drp_den_i,
   input  logic              drp_dwe_i,
   input  logic [DRP_DW-1:0] drp_di_i,
   output logic [DRP_DW-1:0] drp_do_o,
   output logic              drp_drdy_o,
   input  logic              pll_rst_i,
   output logic              pll_locked_o,
   input  logic              err_clr_i,
   output logic              err_busy_o,
   output logic              err_unsafe_wr_o,
   output logic [7:0]        wr_count_o
);
   drp_state_t        r_state;
   logic [3:0]        r_cnt;
   logic [DRP_AW-1:0] r_addr;
   logic [DRP_DW-1:0] r_di;
   logic [DRP_DW-1:0] r_regs [DRP_NREG];
   logic [DRP_DW-1:0] r_do;
   logic              r_drdy;
   logic [ERR_W-1:0]  r_err;
   logic [7:0]        r_wr_count;

   logic              w_done;
   logic [ERR_W-1:0]  w_err_set;

   assign w_done = (r_state != ST_IDLE) && (r_cnt == 4'd0);

   always_comb begin
      w_err_set             = '0;
      w_err_set[ERR_BUSY]   = drp_den_i && (r_state != ST_IDLE);
      w_err_set[ERR_UNSAFE] = w_done && (r_state == ST_WR_WAIT) && !pll_rst_i;
   end

   always_ff @(posedge clk_a_i or posedge rst_powerup) begin
      if (rst_powerup) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_di       <= '0;
         r_do       <= '0;
         r_drdy     <= 1'b0;
         r_err      <= '0;
         r_wr_count <= '0;
         for (int k = 0; k < DRP_NREG; k++)
            r_regs[k] <= drp_init_val(g_init_base, k);
      end else begin
         r_drdy <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (drp_den_i) begin
                  r_addr <= drp_daddr_i;
                  r_di   <= drp_di_i;
                  if (drp_dwe_i) begin
                     r_cnt   <= 4'(g_write_latency - 1);
                     r_state <= ST_WR_WAIT;
                  end else begin
                     r_cnt   <= 4'(g_read_latency - 1);
                     r_state <= ST_RD_WAIT;
                  end
               end
            end
            default: begin
               if (w_done) begin
                  r_drdy  <= 1'b1;
                  r_state <= ST_IDLE;
                  if (r_state == ST_RD_WAIT) begin
                     r_do <= r_regs[r_addr];
                  end else begin
                     r_regs[r_addr] <= r_di;
                     r_wr_count     <= r_wr_count + 8'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
         endcase
         // a new error on the clearing edge must survive the clear
         r_err <= (r_err & ~{ERR_W{err_clr_i}}) | w_err_set;
      end
   end

   pll_drp_lock_model #(
      .g_lock_delay (g_lock_delay)
   ) u_lock (
      .clk_a_i      (clk_a_i),
      .rst_powerup  (rst_powerup),
      .pll_rst_i    (pll_rst_i),
      .pll_locked_o (pll_locked_o)
   );

   assign drp_do_o        = r_do;
   assign drp_drdy_o      = r_drdy;
   assign err_busy_o      = r_err[ERR_BUSY];
   assign err_unsafe_wr_o = r_err[ERR_UNSAFE];
   assign wr_count_o      = r_wr_count;
endmodule

// File: tb/tb_pll_drp_responder.sv
// Directed bench for pll_drp_responder with hand-computed expectations.
`timescale 1ns/1ps
module tb_pll_drp_responder;
   logic        clk_a_i = 1'b0;
   logic        rst_powerup;
   logic [4:0]  drp_daddr_i;
   logic        drp_den_i;
   logic        drp_dwe_i;
   logic [15:0] drp_di_i;
   logic [15:0] drp_do_o;
   logic        drp_drdy_o;
   logic        pll_rst_i;
   logic        pll_locked_o;
   logic        err_clr_i;
   logic        err_busy_o;
   logic        err_unsafe_wr_o;
   logic [7:0]  wr_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_a_i = ~clk_a_i;

   pll_drp_responder dut (
      .clk_a_i         (clk_a_i),
      .rst_powerup     (rst_powerup),
      .drp_daddr_i     (drp_daddr_i),
      .drp_den_i       (drp_den_i),
      .drp_dwe_i       (drp_dwe_i),
      .drp_di_i        (drp_di_i),
      .drp_do_o        (drp_do_o),
      .drp_drdy_o      (drp_drdy_o),
      .pll_rst_i       (pll_rst_i),
      .pll_locked_o    (pll_locked_o),
      .err_clr_i       (err_clr_i),
      .err_busy_o      (err_busy_o),
      .err_unsafe_wr_o (err_unsafe_wr_o),
      .wr_count_o      (wr_count_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called and returns at posedge+1ns; checks drdy timing and pulse width.
   task automatic drp(input logic [4:0] a, input logic we,
                      input logic [15:0] d, input int lat,
                      input string tag, output logic [15:0] rd);
      drp_daddr_i = a;
      drp_dwe_i   = we;
      drp_di_i    = d;
      drp_den_i   = 1'b1;
      @(posedge clk_a_i); #1;
      drp_den_i = 1'b0;
      drp_dwe_i = 1'b0;
      repeat (lat - 1) begin
         @(posedge clk_a_i); #1;
         chk({tag, "_early"}, 32'(drp_drdy_o), 32'd0);
      end
      @(posedge clk_a_i); #1;
      chk({tag, "_drdy"}, 32'(drp_drdy_o), 32'd1);
      rd = drp_do_o;
      @(posedge clk_a_i); #1;
      chk({tag, "_pulse"}, 32'(drp_drdy_o), 32'd0);
   endtask

   task automatic lock_wait(output int n);
      n = 0;
      do begin
         @(posedge clk_a_i); #1;
         n++;
      end while (!pll_locked_o && n < 200);
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] nv;
      int          n;
      int          pulses;
      logic [15:0] pdo;

      rst_powerup = 1'b1;
      drp_daddr_i = '0;
      drp_den_i   = 1'b0;
      drp_dwe_i   = 1'b0;
      drp_di_i    = '0;
      pll_rst_i   = 1'b1;
      err_clr_i   = 1'b0;
      repeat (3) @(posedge clk_a_i);
      #1 rst_powerup = 1'b0;

      chk("rst_drdy", 32'(drp_drdy_o), 32'd0);
      chk("rst_do", 32'(drp_do_o), 32'd0);
      chk("rst_locked", 32'(pll_locked_o), 32'd0);
      chk("rst_busy", 32'(err_busy_o), 32'd0);
      chk("rst_unsafe", 32'(err_unsafe_wr_o), 32'd0);
      chk("rst_wrcnt", 32'(wr_count_o), 32'd0);

      drp(5'd5, 1'b0, 16'h0, 3, "rd5_init", rd);
      chk("rd5_init_val", 32'(rd), 32'h0000A505);
      chk("rd5_do_held", 32'(drp_do_o), 32'h0000A505);
      chk("rd5_locked", 32'(pll_locked_o), 32'd0);

      drp(5'd5, 1'b1, 16'h1234, 2, "wr5", rd);
      chk("wr5_cnt", 32'(wr_count_o), 32'd1);
      chk("wr5_do_unchanged", 32'(drp_do_o), 32'h0000A505);
      drp(5'd5, 1'b0, 16'h0, 3, "rd5_new", rd);
      chk("rd5_new_val", 32'(rd), 32'h00001234);
      chk("wr5_unsafe", 32'(err_unsafe_wr_o), 32'd0);

      pll_rst_i = 1'b0;
      drp(5'd6, 1'b1, 16'hBEEF, 2, "wr6_unsafe", rd);
      chk("unsafe_set", 32'(err_unsafe_wr_o), 32'd1);
      chk("unsafe_busy", 32'(err_busy_o), 32'd0);
      err_clr_i = 1'b1;
      @(posedge clk_a_i); #1;
      err_clr_i = 1'b0;
      chk("unsafe_clr", 32'(err_unsafe_wr_o), 32'd0);

      err_clr_i   = 1'b1;
      drp_daddr_i = 5'd6;
      drp_dwe_i   = 1'b1;
      drp_di_i    = 16'hCAFE;
      drp_den_i   = 1'b1;
      @(posedge clk_a_i); #1;
      drp_den_i = 1'b0;
      drp_dwe_i = 1'b0;
      @(posedge clk_a_i); #1;
      chk("clrwin_pre", 32'(err_unsafe_wr_o), 32'd0);
      @(posedge clk_a_i); #1;
      err_clr_i = 1'b0;
      chk("clrwin_drdy", 32'(drp_drdy_o), 32'd1);
      chk("clrwin_unsafe", 32'(err_unsafe_wr_o), 32'd1);
      chk("clrwin_cnt", 32'(wr_count_o), 32'd3);
      chk("clrwin_do", 32'(drp_do_o), 32'h00001234);
      @(posedge clk_a_i); #1;

      pll_rst_i   = 1'b1;
      drp_daddr_i = 5'd7;
      drp_dwe_i   = 1'b0;
      drp_den_i   = 1'b1;
      @(posedge clk_a_i); #1;
      drp_dwe_i = 1'b1;
      drp_di_i  = 16'hDEAD;
      @(posedge clk_a_i); #1;
      drp_den_i = 1'b0;
      drp_dwe_i = 1'b0;
      chk("busy_set", 32'(err_busy_o), 32'd1);
      pulses = 0;
      pdo    = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_a_i); #1;
         if (drp_drdy_o) begin
            pulses++;
            pdo = drp_do_o;
         end
      end
      chk("busy_pulses", 32'(pulses), 32'd1);
      chk("busy_rd_val", 32'(pdo), 32'h0000A507);
      chk("busy_wrcnt", 32'(wr_count_o), 32'd3);
      drp(5'd7, 1'b0, 16'h0, 3, "rd7_after", rd);
      chk("rd7_unchanged", 32'(rd), 32'h0000A507);
      err_clr_i = 1'b1;
      @(posedge clk_a_i); #1;
      err_clr_i = 1'b0;
      chk("busy_clr", 32'(err_busy_o), 32'd0);
      chk("busy_clr_unsafe", 32'(err_unsafe_wr_o), 32'd0);

      repeat (4) @(posedge clk_a_i);
      #1 pll_rst_i = 1'b0;
      lock_wait(n);
      chk("lock_delay", 32'(n), 32'd100);
      repeat (3) @(posedge clk_a_i);
      #1 chk("lock_hold", 32'(pll_locked_o), 32'd1);
      pll_rst_i = 1'b1;
      @(posedge clk_a_i); #1;
      chk("lock_drop", 32'(pll_locked_o), 32'd0);
      repeat (4) @(posedge clk_a_i);
      #1 pll_rst_i = 1'b0;
      repeat (50) @(posedge clk_a_i);
      #1 pll_rst_i = 1'b1;
      chk("lock_mid_pre", 32'(pll_locked_o), 32'd0);
      @(posedge clk_a_i); #1;
      pll_rst_i = 1'b0;
      lock_wait(n);
      chk("lock_restart", 32'(n), 32'd100);

      pll_rst_i   = 1'b1;
      drp_daddr_i = 5'd8;
      drp_dwe_i   = 1'b1;
      drp_di_i    = 16'hFFFF;
      drp_den_i   = 1'b1;
      @(posedge clk_a_i); #1;
      drp_den_i = 1'b0;
      drp_dwe_i = 1'b0;
      @(posedge clk_a_i); #1;
      rst_powerup = 1'b1;
      #2;
      chk("midrst_drdy", 32'(drp_drdy_o), 32'd0);
      chk("midrst_wrcnt", 32'(wr_count_o), 32'd0);
      chk("midrst_locked", 32'(pll_locked_o), 32'd0);
      @(posedge clk_a_i); #1;
      rst_powerup = 1'b0;
      @(posedge clk_a_i); #1;
      chk("midrst_no_drdy", 32'(drp_drdy_o), 32'd0);

      for (int i = 0; i < 4; i++) begin
         drp(5'(8 + i), 1'b0, 16'h0, 3, "rmw_rd", rd);
         nv = (rd & 16'hFF00) | 16'h0012;
         drp(5'(8 + i), 1'b1, nv, 2, "rmw_wr", rd);
      end
      chk("rmw_wrcnt", 32'(wr_count_o), 32'd4);
      chk("rmw_unsafe", 32'(err_unsafe_wr_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drp(5'(8 + i), 1'b0, 16'h0, 3, "rmw_chk", rd);
         chk("rmw_val", 32'(rd), 32'h0000A512);
      end
      pll_rst_i = 1'b0;
      lock_wait(n);
      chk("rmw_lock", 32'(n), 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
